// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU integer-to-float issue/writeback path.
package fpu_pkg;

   localparam int LAT_ITOF  = 2;
   localparam int FPU_TAG_W = 6;

   typedef struct packed {
      logic [31:0]          data;
      logic [FPU_TAG_W-1:0] tag;
   } fpu_wb_entry_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// Result FIFO for the converter writeback path; push and pop may coincide
// at any occupancy, flush empties it in one cycle.
module fpu_wb_fifo
   import fpu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type ENTRY_T = fpu_wb_entry_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_flush,
   input  logic   i_push,
   input  ENTRY_T i_data,
   input  logic   i_pop,
   output ENTRY_T o_data,
   output logic   o_full,
   output logic   o_empty
);
   localparam int AW = $clog2(DEPTH);

   ENTRY_T       r_mem [DEPTH];
   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;
   logic         w_wr;
   logic         w_rd;

   assign o_empty = (r_wr == r_rd);
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_rd    = i_pop & ~o_empty;
   // a pop in the same cycle frees the slot the push needs
   assign w_wr    = i_push & (~o_full | w_rd);
   assign o_data  = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else if (i_flush) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_wr) r_wr <= r_wr + (AW+1)'(1);
         if (w_rd) r_rd <= r_rd + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr & ~i_flush) r_mem[r_wr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/fpu_conv_wb.sv
// Issue/writeback wrapper around the fixed-latency integer-to-float converter:
// tag delay line, credit counter and result FIFO.
module fpu_conv_wb
   import fpu_pkg::*;
#(
   parameter int LATENCY = LAT_ITOF,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic signed [31:0]  req_x,
   input  logic [TAG_W-1:0]    req_tag,
   output logic                unit_valid,
   output logic signed [31:0]  unit_x,
   input  logic [31:0]         unit_y,
   input  logic                unit_done,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [31:0]         wb_data,
   output logic [TAG_W-1:0]    wb_tag,
   output logic                err_sync
);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
   } entry_t;

   // index 0 is loaded on acceptance; index LATENCY lines up with unit_done
   logic [LATENCY:0] r_dl_vld;
   logic [LATENCY:0] r_dl_kill;
   logic [TAG_W-1:0] r_dl_tag [0:LATENCY];
   logic [CW-1:0]    r_used;
   logic             r_err_sync;

   logic             w_accept;
   logic             w_ret;
   logic             w_push;
   logic             w_drop;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CW-1:0]    w_inflight;
   entry_t           w_push_e;
   entry_t           w_head;

   assign req_ready  = rst_n & ~flush & (r_used < CW'(DEPTH));
   assign w_accept   = req_valid & req_ready;
   assign unit_valid = w_accept;
   assign unit_x     = req_x;

   assign w_ret  = r_dl_vld[LATENCY] & unit_done;
   assign w_push = w_ret & ~r_dl_kill[LATENCY] & ~flush;
   assign w_drop = w_ret & r_dl_kill[LATENCY];
   assign w_pop  = wb_valid & wb_ready;

   assign w_push_e.data = unit_y;
   assign w_push_e.tag  = r_dl_tag[LATENCY];

   assign wb_valid = ~w_empty & ~flush;
   assign wb_data  = w_head.data;
   assign wb_tag   = w_head.tag;
   assign err_sync = r_err_sync;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i <= LATENCY; i++) w_inflight = w_inflight + CW'(r_dl_vld[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dl_vld  <= '0;
         r_dl_kill <= '0;
      end else begin
         r_dl_vld  <= {r_dl_vld[LATENCY-1:0], w_accept};
         r_dl_kill <= {r_dl_kill[LATENCY-1:0] | ({LATENCY{flush}} & r_dl_vld[LATENCY-1:0]), 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      r_dl_tag[0] <= req_tag;
      for (int i = 1; i <= LATENCY; i++) r_dl_tag[i] <= r_dl_tag[i-1];
   end

   // on flush the credits still held are exactly the entries left in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_used     <= '0;
         r_err_sync <= 1'b0;
      end else begin
         if (flush) r_used <= w_inflight - CW'(w_ret);
         else       r_used <= r_used + CW'(w_accept) - CW'(w_pop) - CW'(w_drop);
         if ((unit_done != r_dl_vld[LATENCY]) || (w_push & w_full & ~w_pop))
            r_err_sync <= 1'b1;
      end
   end

   fpu_wb_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_T (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_push  (w_push),
      .i_data  (w_push_e),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule
